// File: rtl/dpram_port_arbiter.sv
// Arbiter between two cores and a shared dual-port data RAM: serialises same-address hazards with alternating priority.
// Optional conflict counter output enabled by defining ARB_CONFLICT_CNT_EN.
module dpram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_stall,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_stall,
    output logic              b_rvalid,
    output logic              ram_ena,
    output logic              ram_enb,
    output logic              ram_wea,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dina,
    output logic [DATA_W-1:0] ram_dinb
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic                holdWe_q, holdWe_d;
    logic [ADDR_W-1:0]   holdAddr_q, holdAddr_d;
    logic [DATA_W-1:0]   holdData_q, holdData_d;
    logic                aRvalid_q, bRvalid_q;

    logic                liveConflict;
    logic                heldVsA;
    logic                heldVsB;
    logic                conflictSeen;

    // Hazard terms: live-vs-live in IDLE, and held-vs-live for the free port in HOLD
    assign liveConflict = a_en & b_en & (a_addr == b_addr) & (a_we | b_we);
    assign heldVsA      = a_en & (a_addr == holdAddr_q) & (holdWe_q | a_we);
    assign heldVsB      = b_en & (b_addr == holdAddr_q) & (holdWe_q | b_we);

    always_comb begin
        conflictSeen = 1'b0;
        case (state_q)
            IDLE:    conflictSeen = liveConflict;
            HOLD_A:  conflictSeen = heldVsB;
            HOLD_B:  conflictSeen = heldVsA;
            default: conflictSeen = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            holdWe_q   <= 1'b0;
            holdAddr_q <= '0;
            holdData_q <= '0;
            aRvalid_q  <= 1'b0;
            bRvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            holdWe_q   <= holdWe_d;
            holdAddr_q <= holdAddr_d;
            holdData_q <= holdData_d;
            aRvalid_q  <= ram_ena & ~ram_wea;
            bRvalid_q  <= ram_enb & ~ram_web;
        end
    end

    // The loser of any conflict is parked in the single hold register; only one port can be parked at a time
    always_comb begin
        state_d    = IDLE;
        prio_d     = prio_q;
        holdWe_d   = holdWe_q;
        holdAddr_d = holdAddr_q;
        holdData_d = holdData_q;
        case (state_q)
            IDLE: begin
                if (liveConflict) begin
                    prio_d = ~prio_q;
                    if (!prio_q) begin
                        state_d    = HOLD_B;
                        holdWe_d   = b_we;
                        holdAddr_d = b_addr;
                        holdData_d = b_wdata;
                    end else begin
                        state_d    = HOLD_A;
                        holdWe_d   = a_we;
                        holdAddr_d = a_addr;
                        holdData_d = a_wdata;
                    end
                end
            end
            HOLD_A: begin
                if (heldVsB) begin
                    prio_d     = ~prio_q;
                    state_d    = HOLD_B;
                    holdWe_d   = b_we;
                    holdAddr_d = b_addr;
                    holdData_d = b_wdata;
                end
            end
            HOLD_B: begin
                if (heldVsA) begin
                    prio_d     = ~prio_q;
                    state_d    = HOLD_A;
                    holdWe_d   = a_we;
                    holdAddr_d = a_addr;
                    holdData_d = a_wdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Live requests pass straight through unless blocked; a held request always wins its cycle
    always_comb begin
        ram_ena   = a_en;
        ram_wea   = a_we;
        ram_addra = a_addr;
        ram_dina  = a_wdata;
        ram_enb   = b_en;
        ram_web   = b_we;
        ram_addrb = b_addr;
        ram_dinb  = b_wdata;
        a_stall   = 1'b0;
        b_stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (liveConflict) begin
                    if (!prio_q) begin
                        ram_enb = 1'b0;
                        ram_web = 1'b0;
                        b_stall = 1'b1;
                    end else begin
                        ram_ena = 1'b0;
                        ram_wea = 1'b0;
                        a_stall = 1'b1;
                    end
                end
            end
            HOLD_A: begin
                ram_ena   = 1'b1;
                ram_wea   = holdWe_q;
                ram_addra = holdAddr_q;
                ram_dina  = holdData_q;
                if (heldVsB) begin
                    ram_enb = 1'b0;
                    ram_web = 1'b0;
                    b_stall = 1'b1;
                end
            end
            HOLD_B: begin
                ram_enb   = 1'b1;
                ram_web   = holdWe_q;
                ram_addrb = holdAddr_q;
                ram_dinb  = holdData_q;
                if (heldVsA) begin
                    ram_ena = 1'b0;
                    ram_wea = 1'b0;
                    a_stall = 1'b1;
                end
            end
            default: begin
                ram_ena = 1'b0;
                ram_enb = 1'b0;
            end
        endcase
        if (reset) begin
            ram_ena = 1'b0;
            ram_wea = 1'b0;
            ram_enb = 1'b0;
            ram_web = 1'b0;
            a_stall = 1'b0;
            b_stall = 1'b0;
        end
    end

    assign a_rvalid = aRvalid_q;
    assign b_rvalid = bRvalid_q;

`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] conflictCnt_q, conflictCnt_d;

    always_comb begin
        conflictCnt_d = conflictCnt_q;
        if (conflictSeen && (conflictCnt_q != 16'hFFFF)) begin
            conflictCnt_d = conflictCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictCnt_q <= 16'd0;
        end else begin
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign conflict_cnt = conflictCnt_q;
`else
    logic unusedConflict;
    assign unusedConflict = conflictSeen;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed scoreboard bench for dpram_port_arbiter; a small RAM model tracks final memory contents.
// Define ARB_CONFLICT_CNT_EN to also exercise the conflict counter saturation.
module tb_dpram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [9:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_stall, a_rvalid, b_stall, b_rvalid;
    logic        ram_ena, ram_enb, ram_wea, ram_web;
    logic [9:0]  ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_dinb;
`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    dpram_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_stall(a_stall), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_stall(b_stall), .b_rvalid(b_rvalid),
        .ram_ena(ram_ena), .ram_enb(ram_enb), .ram_wea(ram_wea), .ram_web(ram_web),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_dina(ram_dina), .ram_dinb(ram_dinb)
`ifdef ARB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM so final contents can be compared after serialised writes
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_enb && ram_web) mem[ram_addrb] <= ram_dinb;
    end

    typedef struct {
        int sA, sB;
        int eA, wA, adA, dA;
        int eB, wB, adB, dB;
        int rvA, rvB;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int aEn, input int aWe, input int aAddr, input int aData,
                                 input int bEn, input int bWe, input int bAddr, input int bData);
        @(negedge clk);
        a_en    = (aEn != 0);
        a_we    = (aWe != 0);
        a_addr  = aAddr[9:0];
        a_wdata = 32'(aData);
        b_en    = (bEn != 0);
        b_we    = (bWe != 0);
        b_addr  = bAddr[9:0];
        b_wdata = 32'(bData);
    endtask

    task automatic expectCycle(input int sA, input int sB,
                               input int eA, input int wA, input int adA, input int dA,
                               input int eB, input int wB, input int adB, input int dB,
                               input int rvA, input int rvB);
        exp_t e;
        e.sA = sA; e.sB = sB;
        e.eA = eA; e.wA = wA; e.adA = adA; e.dA = dA;
        e.eB = eB; e.wB = wB; e.adB = adB; e.dB = dB;
        e.rvA = rvA; e.rvB = rvB;
        scb.push_back(e);
    endtask

    task automatic checkOutput(input string step);
        exp_t e;
        #2;
        if (scb.size() == 0) begin
            chk({step, ".scbEmpty"}, 32'(scb.size()), 32'd1);
        end else begin
            e = scb.pop_front();
            chk({step, ".aStall"}, 32'(a_stall), e.sA);
            chk({step, ".bStall"}, 32'(b_stall), e.sB);
            chk({step, ".ramEna"}, 32'(ram_ena), e.eA);
            chk({step, ".ramWea"}, 32'(ram_wea), e.wA);
            chk({step, ".ramEnb"}, 32'(ram_enb), e.eB);
            chk({step, ".ramWeb"}, 32'(ram_web), e.wB);
            chk({step, ".aRvalid"}, 32'(a_rvalid), e.rvA);
            chk({step, ".bRvalid"}, 32'(b_rvalid), e.rvB);
            if (e.eA != 0) begin
                chk({step, ".ramAddra"}, 32'(ram_addra), e.adA);
                if (e.wA != 0) chk({step, ".ramDina"}, ram_dina, e.dA);
            end
            if (e.eB != 0) begin
                chk({step, ".ramAddrb"}, 32'(ram_addrb), e.adB);
                if (e.wB != 0) chk({step, ".ramDinb"}, ram_dinb, e.dB);
            end
        end
    endtask

    task automatic goIdle(input string step, input int rvA, input int rvB);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        expectCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rvA, rvB);
        checkOutput(step);
    endtask

    initial begin
        // Conflict presented while reset is held: everything must stay quiet
        a_en = 1'b1; a_we = 1'b1; a_addr = 10'd1;
        b_en = 1'b1; b_we = 1'b1; b_addr = 10'd1;
        expectCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("inReset");
        a_en = 1'b0; b_en = 1'b0; a_we = 1'b0; b_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1, 1, 5, 'h11, 1, 0, 9, 0);
        expectCycle(0, 0, 1, 1, 5, 'h11, 1, 0, 9, 0, 0, 0);
        checkOutput("wrRdDiff");
        goIdle("wrRdDiff+1", 0, 1);

        applyStimulus(1, 0, 3, 0, 1, 0, 3, 0);
        expectCycle(0, 0, 1, 0, 3, 0, 1, 0, 3, 0, 0, 0);
        checkOutput("rdRdSame");
        goIdle("rdRdSame+1", 1, 1);

        // Write-write, A wins on prio 0
        applyStimulus(1, 1, 7, 'hAA, 1, 1, 7, 'hBB);
        expectCycle(0, 1, 1, 1, 7, 'hAA, 0, 0, 0, 0, 0, 0);
        checkOutput("ww1");
        applyStimulus(0, 0, 0, 0, 1, 1, 7, 'hBB);
        expectCycle(0, 0, 0, 0, 0, 0, 1, 1, 7, 'hBB, 0, 0);
        checkOutput("ww1Hold");
        goIdle("ww1Done", 0, 0);
        chk("mem7First", mem[7], 32'hBB);

        // Same conflict again, B wins now
        applyStimulus(1, 1, 7, 'hAA, 1, 1, 7, 'hBB);
        expectCycle(1, 0, 0, 0, 0, 0, 1, 1, 7, 'hBB, 0, 0);
        checkOutput("ww2");
        applyStimulus(1, 1, 7, 'hAA, 0, 0, 0, 0);
        expectCycle(0, 0, 1, 1, 7, 'hAA, 0, 0, 0, 0, 0, 0);
        checkOutput("ww2Hold");
        goIdle("ww2Done", 0, 0);
        chk("mem7Second", mem[7], 32'hAA);

        // Chained conflict: A collides with held B in the HOLD_B cycle
        applyStimulus(1, 1, 4, 'h44, 1, 1, 4, 'h55);
        expectCycle(0, 1, 1, 1, 4, 'h44, 0, 0, 0, 0, 0, 0);
        checkOutput("chain0");
        applyStimulus(1, 1, 4, 'h66, 1, 1, 4, 'h55);
        expectCycle(1, 0, 0, 0, 0, 0, 1, 1, 4, 'h55, 0, 0);
        checkOutput("chainHoldB");
        applyStimulus(1, 1, 4, 'h66, 0, 0, 0, 0);
        expectCycle(0, 0, 1, 1, 4, 'h66, 0, 0, 0, 0, 0, 0);
        checkOutput("chainHoldA");
        goIdle("chainDone", 0, 0);
        chk("mem4", mem[4], 32'h66);

        // Losing read on B, then losing read on A
        applyStimulus(1, 1, 8, 'h77, 1, 0, 8, 0);
        expectCycle(0, 1, 1, 1, 8, 'h77, 0, 0, 0, 0, 0, 0);
        checkOutput("rdLoseB");
        applyStimulus(0, 0, 0, 0, 1, 0, 8, 0);
        expectCycle(0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0);
        checkOutput("rdLoseBHold");
        applyStimulus(1, 0, 8, 0, 1, 1, 8, 'h88);
        expectCycle(1, 0, 0, 0, 0, 0, 1, 1, 8, 'h88, 0, 1);
        checkOutput("rdLoseA");
        applyStimulus(1, 0, 8, 0, 0, 0, 0, 0);
        expectCycle(0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdLoseAHold");
        goIdle("rdLoseDone", 1, 0);
        chk("mem8", mem[8], 32'h88);

        // Reset pulsed during HOLD_B drops the held write
        applyStimulus(1, 1, 2, 'h22, 1, 1, 2, 'h33);
        expectCycle(0, 1, 1, 1, 2, 'h22, 0, 0, 0, 0, 0, 0);
        checkOutput("rstConflict");
        applyStimulus(0, 0, 0, 0, 1, 1, 2, 'h33);
        reset = 1'b1;
        expectCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstInHold");
        b_en = 1'b0; b_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        goIdle("rstAfter", 0, 0);
        chk("mem2", mem[2], 32'h22);

        // After reset A must win again (prio back to 0, state IDLE)
        applyStimulus(1, 1, 1, 'h01, 1, 1, 1, 'h02);
        expectCycle(0, 1, 1, 1, 1, 'h01, 0, 0, 0, 0, 0, 0);
        checkOutput("postRst");
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 'h02);
        expectCycle(0, 0, 0, 0, 0, 0, 1, 1, 1, 'h02, 0, 0);
        checkOutput("postRstHold");
        goIdle("postRstDone", 0, 0);
        chk("mem1", mem[1], 32'h02);

`ifdef ARB_CONFLICT_CNT_EN
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("cntReset0", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 1, 0, 1, 1, 1, 0, 2);
        repeat (70000) @(negedge clk);
        #2;
        chk("cntSaturate", 32'(conflict_cnt), 32'hFFFF);
        reset = 1'b1;
        #1;
        chk("cntResetAgain", 32'(conflict_cnt), 32'd0);
        a_en = 1'b0; b_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
